// File: rtl/mips_fetch_unit_pkg.sv
// mips_fetch_unit_pkg: shared MIPS front-end constants, encodings and fetch queue entry type
// Contents: reset PC default, NOP encoding, opcode/funct/micro-op enums,
// fetch queue entry struct and the redirect word-alignment helper.
package mips_fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0010_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0000;

   typedef enum logic [5:0] {
      OP_SPECIAL = 6'h00,
      OP_REGIMM  = 6'h01,
      OP_J       = 6'h02,
      OP_JAL     = 6'h03,
      OP_BEQ     = 6'h04,
      OP_BNE     = 6'h05,
      OP_ADDIU   = 6'h09,
      OP_LW      = 6'h23,
      OP_SW      = 6'h2b
   } opcode_e;

   typedef enum logic [5:0] {
      FUNC_SLL  = 6'h00,
      FUNC_JR   = 6'h08,
      FUNC_JALR = 6'h09,
      FUNC_ADDU = 6'h21,
      FUNC_SUBU = 6'h23
   } funct_e;

   typedef enum logic [3:0] {
      UOP_NOP,
      UOP_ALU,
      UOP_LOAD,
      UOP_STORE,
      UOP_BRANCH,
      UOP_JUMP
   } uop_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: fetch unit bus bundle (instruction memory side and decode side)
// Memory side : imem_req_valid/ready/addr request handshake, imem_resp_valid/data in-order responses.
// Decode side : inst_valid/ready/data/pc queue head handshake, redirect_valid/pc taken-branch target.
// master = fetch unit view, slave = memory + decode view.
interface mips_fetch_unit_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/mips_fetch_unit_sync_fifo.sv
// sync_fifo: generic synchronous FIFO with flush and occupancy count
// Ports: clk, reset (sync, active-high), flush (empties FIFO), push/wr_data,
// pop/rd_data (head, valid when count != 0), count (0..DEPTH).
// Push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign do_pop  = pop & (count != '0);
   assign do_push = push & ((count != FULL) | do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset | flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push & ~flush) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: MIPS instruction fetch with credit-based request issue and a decoupling queue
// Ports: clk, reset (sync, active-high), bus (mips_fetch_unit_if.master):
//   imem_req_*  word-aligned requests at fetch_pc, imem_resp_* in-order responses,
//   inst_*      queue head toward decode, redirect_* taken jump/branch target.
// Parameters: RESET_PC first fetch address, DEPTH queue entries (power of two, 2..16).
module mips_fetch_unit
   import mips_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 4
) (
   input logic                clk,
   input logic                reset,
   mips_fetch_unit_if.master  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW+1:0] CREDITS = (AW+2)'(DEPTH);

   logic [31:0]  fetch_pc, resp_pc;
   logic [AW:0]  outstanding, q_count, discard_cnt;
   logic         accept, resp_keep, pop, q_valid;
   fetch_entry_t q_in, q_head;

   // Queued plus in-flight never exceeds DEPTH, so every kept response has a free slot.
   assign bus.imem_req_valid = ~reset & ~bus.redirect_valid &
                               (({1'b0, q_count} + {1'b0, outstanding}) < CREDITS);
   assign bus.imem_req_addr  = fetch_pc;
   assign accept             = bus.imem_req_valid & bus.imem_req_ready;

   // A response arriving with a redirect belongs to the old path and is dropped.
   assign resp_keep = bus.imem_resp_valid & (discard_cnt == '0) & ~bus.redirect_valid;
   assign q_in      = '{pc: resp_pc, data: bus.imem_resp_data};

   assign q_valid        = q_count != '0;
   assign pop            = q_valid & bus.inst_ready;
   assign bus.inst_valid = q_valid;
   assign bus.inst_data  = q_valid ? q_head.data : NOP_INST;
   assign bus.inst_pc    = q_valid ? q_head.pc : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         discard_cnt <= '0;
      end else if (bus.redirect_valid) begin
         fetch_pc    <= word_align(bus.redirect_pc);
         discard_cnt <= outstanding - {{AW{1'b0}}, bus.imem_resp_valid};
      end else begin
         if (accept) fetch_pc <= fetch_pc + 32'd4;
         if (bus.imem_resp_valid && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
      end
   end

   // Issued addresses; its occupancy is the outstanding-request count, and every
   // response (kept or dropped) retires its entry, so it never needs flushing.
   sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) pc_fifo (
      .clk,
      .reset,
      .flush   (1'b0),
      .push    (accept),
      .pop     (bus.imem_resp_valid),
      .wr_data (fetch_pc),
      .rd_data (resp_pc),
      .count   (outstanding)
   );

   sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) inst_q (
      .clk,
      .reset,
      .flush   (bus.redirect_valid),
      .push    (resp_keep),
      .pop     (pop),
      .wr_data (q_in),
      .rd_data (q_head),
      .count   (q_count)
   );

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed + randomized bench for mips_fetch_unit against a stream-level model
module tb_mips_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0010_0000;
   localparam int          DEPTH    = 4;

   logic clk, reset;
   mips_fetch_unit_if bus();

   mips_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_5EED;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory model: in-order responses, per-request latency in [lat_min, lat_max].
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   mreq_t mq[$];
   int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1, rdy_ctl = 1;
   logic m_acc, m_fire, m_rst;
   logic [31:0] m_addr;
   int m_d;

   always @(posedge clk) begin
      m_acc  = bus.imem_req_valid & bus.imem_req_ready;
      m_addr = bus.imem_req_addr;
      m_fire = bus.imem_resp_valid;
      m_rst  = reset;
      #2;
      cyc++;
      if (m_rst) begin
         mq.delete();
         last_due = 0;
      end else begin
         if (m_fire) void'(mq.pop_front());
         if (m_acc) begin
            m_d = cyc + $urandom_range(lat_max, lat_min) - 1;
            if (m_d <= last_due) m_d = last_due + 1;
            last_due = m_d;
            mq.push_back('{addr: m_addr, due: m_d});
         end
      end
      bus.imem_resp_valid = (mq.size() != 0) && (mq[0].due <= cyc);
      bus.imem_resp_data  = bus.imem_resp_valid ? mem_word(mq[0].addr) : 32'h0;
      bus.imem_req_ready  = (rdy_ctl == 2) ? 1'($urandom_range(1, 0)) : (rdy_ctl == 1);
   end

   // Stream model: after reset or a redirect, decode sees consecutive words from the
   // new start address, and requests walk the same way; a same-cycle pop precedes the redirect.
   logic [31:0] exp_pc, exp_fa, prev_addr;
   logic prev_stall = 1'b0;
   int n_pop = 0, n_accept = 0;

   always @(negedge clk) begin
      if (reset) begin
         exp_pc = RESET_PC;
         exp_fa = RESET_PC;
         prev_stall = 1'b0;
      end else begin
         if (bus.inst_valid && bus.inst_ready) begin
            chk("pop_pc", bus.inst_pc, exp_pc);
            chk("pop_data", bus.inst_data, mem_word(exp_pc));
            exp_pc += 32'd4;
            n_pop++;
         end
         if (bus.redirect_valid) begin
            chk("req_off_on_redirect", bus.imem_req_valid, 1'b0);
            exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
            exp_fa = exp_pc;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("req_hold_valid", bus.imem_req_valid, 1'b1);
               chk("req_hold_addr", bus.imem_req_addr, prev_addr);
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
               chk("req_addr", bus.imem_req_addr, exp_fa);
               exp_fa += 32'd4;
               n_accept++;
            end
            prev_stall = bus.imem_req_valid & ~bus.imem_req_ready;
            prev_addr  = bus.imem_req_addr;
         end
         chk("outstanding_bound", 32'(mq.size() <= DEPTH), 1);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      step(3);
      reset = 1'b0;
   endtask

   task automatic wait_inst_valid(input int lim, input string tag);
      int n = 0;
      @(negedge clk);
      while (!bus.inst_valid && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, bus.inst_valid, 1'b1);
   endtask

   initial begin
      int a0, p0;
      logic found;
      reset = 1'b1;
      bus.inst_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      // reset values and sequential streaming with 1-cycle memory
      step(1);
      @(negedge clk);
      chk("rst_req_valid", bus.imem_req_valid, 1'b0);
      chk("rst_inst_valid", bus.inst_valid, 1'b0);
      chk("rst_inst_data", bus.inst_data, 32'h0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);
      step(1);
      apply_reset();
      @(negedge clk);
      chk("first_req_valid", bus.imem_req_valid, 1'b1);
      chk("first_req_addr", bus.imem_req_addr, RESET_PC);
      @(negedge clk);
      chk("lat_cycle1_inst_valid", bus.inst_valid, 1'b0);
      chk("second_req_addr", bus.imem_req_addr, RESET_PC + 32'd4);
      @(negedge clk);
      chk("lat_cycle2_inst_valid", bus.inst_valid, 1'b1);
      chk("lat_cycle2_inst_pc", bus.inst_pc, RESET_PC);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("stream_inst_valid", bus.inst_valid, 1'b1);
      end
      // decode stalled: credits cap requests at DEPTH
      @(posedge clk); #1;
      bus.inst_ready = 1'b0;
      apply_reset();
      a0 = n_accept;
      repeat (20) @(negedge clk);
      chk("stall_accepts", n_accept - a0, DEPTH);
      chk("stall_req_valid", bus.imem_req_valid, 1'b0);
      chk("stall_inst_valid", bus.inst_valid, 1'b1);
      chk("stall_head_pc", bus.inst_pc, RESET_PC);
      @(posedge clk); #1;
      bus.inst_ready = 1'b1;
      p0 = n_pop;
      step(12);
      chk("stall_resume_pops", 32'(n_pop - p0 >= 8), 1);
      // redirect with three requests in flight
      lat_min = 5; lat_max = 5;
      apply_reset();
      step(3);
      rdy_ctl = 0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0010_0200;
      @(negedge clk);
      chk("redir_outstanding", mq.size(), 3);
      step(1);
      bus.redirect_valid = 1'b0;
      rdy_ctl = 1;
      wait_inst_valid(60, "redir_inst_valid");
      chk("redir_first_pc", bus.inst_pc, 32'h0010_0200);
      // redirect coincident with a response and a pop
      lat_min = 1; lat_max = 1;
      apply_reset();
      step(6);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clk); #3;
         if (bus.imem_resp_valid && bus.inst_valid) found = 1'b1;
      end
      chk("coincide_found", found, 1'b1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0010_0400;
      @(negedge clk);
      chk("coincide_pop_delivered", bus.inst_valid, 1'b1);
      step(1);
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("coincide_flushed", bus.inst_valid, 1'b0);
      wait_inst_valid(20, "coincide_inst_valid");
      chk("coincide_first_pc", bus.inst_pc, 32'h0010_0400);
      // random stalls, latency 1..5, random redirects and a mid-run reset
      lat_min = 1; lat_max = 5; rdy_ctl = 2;
      apply_reset();
      p0 = n_pop;
      for (int i = 0; i < 800; i++) begin
         step(1);
         bus.inst_ready = ($urandom_range(3, 0) != 0);
         bus.redirect_valid = ($urandom_range(39, 0) == 0);
         bus.redirect_pc = 32'h0010_0000 + (32'($urandom_range(255, 0)) << 2) + 32'($urandom_range(3, 0));
         reset = (i >= 400 && i < 402);
      end
      chk("random_progress", 32'(n_pop - p0 > 50), 1);
      // address wrap at the top of memory
      step(1);
      lat_min = 1; lat_max = 1; rdy_ctl = 1;
      bus.inst_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFB;
      step(1);
      bus.redirect_valid = 1'b0;
      wait_inst_valid(40, "wrap_valid0");
      chk("wrap_pc0", bus.inst_pc, 32'hFFFF_FFF8);
      wait_inst_valid(40, "wrap_valid1");
      chk("wrap_pc1", bus.inst_pc, 32'hFFFF_FFFC);
      wait_inst_valid(40, "wrap_valid2");
      chk("wrap_pc2", bus.inst_pc, 32'h0000_0000);
      step(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
